// File: rtl/ex_divider_pkg.sv
// Shared divider types.
//   div_state : divider FSM state encoding (IDLE, CALC, DONE)
//   div_f     : function select encoding carried on s_f_i
package p_hardisc;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state;

    typedef enum logic [1:0] {
        DIV_F_DIV  = 2'b00,
        DIV_F_DIVU = 2'b01,
        DIV_F_REM  = 2'b10,
        DIV_F_REMU = 2'b11
    } div_f;

endpackage

// File: rtl/ex_divider_seu_regs.sv
// Plain storage register exposed as its own instance so each piece of
// divider state can be targeted by upset injection by instance name.
//   s_c_i : clock
//   s_d_i : next value (reset/hold decided by the owner)
//   s_d_o : registered value
module seu_regs #(
    parameter int N = 1
) (
    input  logic         s_c_i,
    input  logic [N-1:0] s_d_i,
    output logic [N-1:0] s_d_o
);

    always_ff @(posedge s_c_i) begin
        s_d_o <= s_d_i;
    end

endmodule

// File: rtl/ex_divider.sv
// Iterative radix-2 restoring divider for the EX stage (DIV/DIVU/REM/REMU).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for s_start_i; operands captured on accept
// CALC  | one restoring step per cycle, counter W-1 down to 0
// DONE  | result valid; held while s_stall_i=1
//
// Ports:
//   s_clk_i    : clock, rising edge
//   s_reset_i  : synchronous active-high reset
//   s_start_i  : start request, operands/function sampled in IDLE
//   s_f_i      : function select (div_f)
//   s_op1_i    : dividend
//   s_op2_i    : divisor
//   s_flush_i  : abort from MA stage, returns to IDLE
//   s_stall_i  : hold the result in DONE
//   s_busy_o   : stall request to lower stages
//   s_valid_o  : result available
//   s_result_o : quotient or remainder, 0 when not valid
module ex_divider
    import p_hardisc::*;
#(
    parameter int W = 32
) (
    input  logic         s_clk_i,
    input  logic         s_reset_i,
    input  logic         s_start_i,
    input  logic [1:0]   s_f_i,
    input  logic [W-1:0] s_op1_i,
    input  logic [W-1:0] s_op2_i,
    input  logic         s_flush_i,
    input  logic         s_stall_i,
    output logic         s_busy_o,
    output logic         s_valid_o,
    output logic [W-1:0] s_result_o
);

    localparam logic [5:0]   CNT_INIT = 6'(W - 1);
    localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};

    logic [1:0]   st_q;
    div_state     st_d;
    div_state     state;
    logic [5:0]   cnt_q, cnt_d;
    logic [W-1:0] quo_q, quo_d;
    logic [W-1:0] rem_q, rem_d;
    logic [W-1:0] dvs_q, dvs_d;
    logic [1:0]   fn_q, fn_d;
    logic         negq_q, negq_d;
    logic         negr_q, negr_d;
    logic [W-1:0] res_q, res_d;

    seu_regs #(.N(2)) EXDIV_STATE    (.s_c_i(s_clk_i), .s_d_i(st_d),   .s_d_o(st_q));
    seu_regs #(.N(6)) EXDIV_COUNTER  (.s_c_i(s_clk_i), .s_d_i(cnt_d),  .s_d_o(cnt_q));
    seu_regs #(.N(W)) EXDIV_QUOTIENT (.s_c_i(s_clk_i), .s_d_i(quo_d),  .s_d_o(quo_q));
    seu_regs #(.N(W)) EXDIV_REMAIN   (.s_c_i(s_clk_i), .s_d_i(rem_d),  .s_d_o(rem_q));
    seu_regs #(.N(W)) EXDIV_DIVISOR  (.s_c_i(s_clk_i), .s_d_i(dvs_d),  .s_d_o(dvs_q));
    seu_regs #(.N(2)) EXDIV_FUNCTION (.s_c_i(s_clk_i), .s_d_i(fn_d),   .s_d_o(fn_q));
    seu_regs #(.N(1)) EXDIV_QSIGN    (.s_c_i(s_clk_i), .s_d_i(negq_d), .s_d_o(negq_q));
    seu_regs #(.N(1)) EXDIV_RSIGN    (.s_c_i(s_clk_i), .s_d_i(negr_d), .s_d_o(negr_q));
    seu_regs #(.N(W)) EXDIV_RESULT   (.s_c_i(s_clk_i), .s_d_i(res_d),  .s_d_o(res_q));

    assign state = div_state'(st_q);

    // Input decode
    div_f         f_in;
    logic         in_signed;
    logic         in_rem;
    logic         op1_neg, op2_neg;
    logic [W-1:0] op1_mag, op2_mag;
    logic         div_zero;
    logic         overflow;
    logic         accept;

    assign f_in = div_f'(s_f_i);

    always_comb begin
        in_signed = 1'b0;
        in_rem    = 1'b0;
        case (f_in)
            DIV_F_DIV:  begin in_signed = 1'b1; in_rem = 1'b0; end
            DIV_F_DIVU: begin in_signed = 1'b0; in_rem = 1'b0; end
            DIV_F_REM:  begin in_signed = 1'b1; in_rem = 1'b1; end
            DIV_F_REMU: begin in_signed = 1'b0; in_rem = 1'b1; end
            default:    begin in_signed = 1'b0; in_rem = 1'b0; end
        endcase
    end

    assign op1_neg  = in_signed & s_op1_i[W-1];
    assign op2_neg  = in_signed & s_op2_i[W-1];
    assign op1_mag  = op1_neg ? -s_op1_i : s_op1_i;
    assign op2_mag  = op2_neg ? -s_op2_i : s_op2_i;
    assign div_zero = (s_op2_i == '0);
    assign overflow = in_signed & (s_op1_i == MIN_NEG) & (s_op2_i == '1);
    assign accept   = (state == IDLE) & s_start_i & ~s_flush_i;

    // Restoring step. The shifted partial remainder needs W+1 bits; since it
    // is always below 2*divisor, bit W of the difference is the borrow.
    logic [W:0]   shifted;
    logic [W:0]   trial;
    logic         fits;
    logic [W-1:0] rem_step, quo_step;
    logic [W-1:0] res_calc;

    assign shifted  = {rem_q, quo_q[W-1]};
    assign trial    = shifted - {1'b0, dvs_q};
    assign fits     = ~trial[W];
    assign rem_step = fits ? trial[W-1:0] : shifted[W-1:0];
    assign quo_step = {quo_q[W-2:0], fits};

    always_comb begin
        res_calc = '0;
        case (div_f'(fn_q))
            DIV_F_DIV, DIV_F_DIVU: res_calc = negq_q ? -quo_step : quo_step;
            DIV_F_REM, DIV_F_REMU: res_calc = negr_q ? -rem_step : rem_step;
            default:               res_calc = '0;
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        st_d   = state;
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        fn_d   = fn_q;
        negq_d = negq_q;
        negr_d = negr_q;
        res_d  = res_q;

        case (state)
            IDLE: begin
                if (accept) begin
                    fn_d   = s_f_i;
                    negq_d = op1_neg ^ op2_neg;
                    negr_d = op1_neg;
                    quo_d  = op1_mag;
                    rem_d  = '0;
                    dvs_d  = op2_mag;
                    if (div_zero) begin
                        st_d  = DONE;
                        res_d = in_rem ? s_op1_i : '1;
                    end else if (overflow) begin
                        st_d  = DONE;
                        res_d = in_rem ? '0 : MIN_NEG;
                    end else begin
                        st_d  = CALC;
                        cnt_d = CNT_INIT;
                    end
                end
            end
            CALC: begin
                quo_d = quo_step;
                rem_d = rem_step;
                if (cnt_q == 6'd0) begin
                    st_d  = DONE;
                    res_d = res_calc;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            DONE: begin
                if (!s_stall_i) begin
                    st_d = IDLE;
                end
            end
            default: begin
                st_d = IDLE;
            end
        endcase

        if (s_flush_i) begin
            st_d  = IDLE;
            cnt_d = 6'd0;
        end

        if (s_reset_i) begin
            st_d   = IDLE;
            cnt_d  = 6'd0;
            quo_d  = '0;
            rem_d  = '0;
            dvs_d  = '0;
            fn_d   = 2'b00;
            negq_d = 1'b0;
            negr_d = 1'b0;
            res_d  = '0;
        end
    end

    assign s_valid_o  = (state == DONE);
    assign s_result_o = s_valid_o ? res_q : '0;
    assign s_busy_o   = ~s_reset_i & ((state == CALC) | accept);

endmodule
